// File: rtl/uart_rx_endpoint.sv
// uart_rx_endpoint: 8N1 UART receiver with mid-bit sampling, stop-bit check,
// a first-word-fall-through byte FIFO drained over valid/ready, and sticky
// framing / overflow error flags.
module uart_rx_endpoint #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               rx,
    output logic [7:0]                         m_data,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    output logic                               frame_err,
    output logic                               overflow,
    input  logic                               err_clr,
    output logic                               busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            rx_meta_q, rx_meta_d;
    logic            rx_s_q, rx_s_d;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      mem_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            frame_err_q, frame_err_d;
    logic            overflow_q, overflow_d;

    logic            push_byte;
    logic            frame_set;
    logic            pop;
    logic            full;
    logic            wr_en;
    logic            ovf_set;

    // All state lives here; the line idles high so the synchroniser resets to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Next-state logic: frame sequencing plus bit counter, bit index and shifter.
    always_comb begin
        rx_meta_d = rx;
        rx_s_d    = rx_meta_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    idx_d = '0;
                    state_d = rx_s_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    state_d = rx_s_q ? IDLE : BREAK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BREAK: begin
                cnt_d = '0;
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM outputs: the stop-bit sample either delivers the byte or flags a framing error.
    always_comb begin
        push_byte = 1'b0;
        frame_set = 1'b0;
        busy      = (state_q != IDLE);
        if (state_q == STOP && cnt_q == CNT_FULL) begin
            push_byte = rx_s_q;
            frame_set = !rx_s_q;
        end
    end

    // FIFO bookkeeping: a push into a full FIFO is only accepted if a pop frees a slot the same edge.
    always_comb begin
        pop     = m_valid && m_ready;
        full    = (level_q == DEPTH_L);
        wr_en   = push_byte && (!full || pop);
        ovf_set = push_byte && full && !pop;

        for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_en) begin
            mem_d[wr_ptr_q] = shift_q;
        end

        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

        level_d = level_q;
        if (wr_en && !pop) begin
            level_d = level_q + 1'b1;
        end else if (!wr_en && pop) begin
            level_d = level_q - 1'b1;
        end

        frame_err_d = (frame_err_q && !err_clr) || frame_set;
        overflow_d  = (overflow_q && !err_clr) || ovf_set;
    end

    // Consumer-facing outputs: head entry shown whenever the FIFO is non-empty.
    always_comb begin
        m_valid    = (level_q != '0);
        m_data     = m_valid ? mem_q[rd_ptr_q] : 8'h00;
        fifo_level = level_q;
        frame_err  = frame_err_q;
        overflow   = overflow_q;
    end

endmodule

// File: tb/tb_uart_rx_endpoint.sv
// Self-checking bench for uart_rx_endpoint: directed sequences, a table of
// frames filling the FIFO past full, and randomized frames compared against
// a byte-level queue model.
module tb_uart_rx_endpoint;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [2:0] fifo_level;
    logic       frame_err;
    logic       overflow;
    logic       err_clr;
    logic       busy;

    int checkCount;
    int failCount;

    // Byte-level reference model: received bytes and sticky flags.
    logic [7:0] mq[$];
    logic       mFerr;
    logic       mOvf;

    typedef struct {
        logic [7:0] data;
        logic       stopBit;
        int         expLevel;
        logic       expFerr;
        logic       expOvf;
        logic [7:0] expHead;
    } vec_t;

    vec_t vecs[6];

    uart_rx_endpoint #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .fifo_level(fifo_level),
        .frame_err (frame_err),
        .overflow  (overflow),
        .err_clr   (err_clr),
        .busy      (busy)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against the expected one and tally the result.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive start, eight data bits LSB first and the stop bit; rx is left at the stop value.
    task automatic driveFrame(input logic [7:0] data, input logic stopBit);
        logic [9:0] bits;
        bits = {stopBit, data, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    // Send one complete frame followed by two bit times of idle line.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
        driveFrame(data, stopBit);
        rx = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        #1;
    endtask

    // Pop the head byte and check it.
    task automatic popOne(input string name, input logic [7:0] expected);
        checkOutput({name, "_valid"}, m_valid, 1'b1);
        checkOutput(name, m_data, expected);
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
    endtask

    // Single-cycle err_clr pulse.
    task automatic pulseErrClr();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask

    // Main test sequence.
    initial begin
        checkCount = 0;
        failCount  = 0;
        rst_n   = 1'b0;
        rx      = 1'b1;
        m_ready = 1'b0;
        err_clr = 1'b0;

        vecs[0] = '{data: 8'h01, stopBit: 1'b1, expLevel: 1, expFerr: 1'b0, expOvf: 1'b0, expHead: 8'h01};
        vecs[1] = '{data: 8'h02, stopBit: 1'b1, expLevel: 2, expFerr: 1'b0, expOvf: 1'b0, expHead: 8'h01};
        vecs[2] = '{data: 8'h03, stopBit: 1'b1, expLevel: 3, expFerr: 1'b0, expOvf: 1'b0, expHead: 8'h01};
        vecs[3] = '{data: 8'h04, stopBit: 1'b1, expLevel: 4, expFerr: 1'b0, expOvf: 1'b0, expHead: 8'h01};
        vecs[4] = '{data: 8'h05, stopBit: 1'b1, expLevel: 4, expFerr: 1'b0, expOvf: 1'b1, expHead: 8'h01};
        vecs[5] = '{data: 8'h3C, stopBit: 1'b0, expLevel: 4, expFerr: 1'b1, expOvf: 1'b1, expHead: 8'h01};

        // Reset values while reset is held.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_m_valid", m_valid, 1'b0);
        checkOutput("rst_m_data", m_data, 8'h00);
        checkOutput("rst_level", fifo_level, 3'd0);
        checkOutput("rst_frame_err", frame_err, 1'b0);
        checkOutput("rst_overflow", overflow, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Single frame with latency measured from the first edge that samples rx low.
        fork
            applyStimulus(8'hA5, 1'b1);
            begin
                repeat (154) @(posedge clk);
                #1;
                checkOutput("lat_before", m_valid, 1'b0);
                @(posedge clk);
                #1;
                checkOutput("lat_at155", m_valid, 1'b1);
            end
        join
        checkOutput("single_data", m_data, 8'hA5);
        checkOutput("single_level", fifo_level, 3'd1);
        checkOutput("single_ferr", frame_err, 1'b0);
        popOne("single_pop", 8'hA5);
        checkOutput("single_empty_level", fifo_level, 3'd0);
        checkOutput("single_empty_valid", m_valid, 1'b0);

        // Glitch shorter than half a bit is ignored.
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        checkOutput("glitch_busy_hi", busy, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("glitch_busy_lo", busy, 1'b0);
        checkOutput("glitch_level", fifo_level, 3'd0);
        checkOutput("glitch_ferr", frame_err, 1'b0);
        checkOutput("glitch_ovf", overflow, 1'b0);

        // Framing error then a long break: one error only, and the next frame is clean.
        driveFrame(8'h3C, 1'b0);
        checkOutput("ferr_set", frame_err, 1'b1);
        checkOutput("ferr_level", fifo_level, 3'd0);
        repeat (20 * CPB) @(posedge clk);
        #1;
        pulseErrClr();
        checkOutput("ferr_clr", frame_err, 1'b0);
        repeat (80 * CPB) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        #1;
        checkOutput("break_no_reerr", frame_err, 1'b0);
        checkOutput("break_level", fifo_level, 3'd0);
        checkOutput("break_busy", busy, 1'b0);
        applyStimulus(8'h81, 1'b1);
        checkOutput("after_break_level", fifo_level, 3'd1);
        checkOutput("after_break_ferr", frame_err, 1'b0);
        popOne("after_break_pop", 8'h81);

        // Table of frames into a FIFO nobody drains: fills, overflows, then a framing error.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].data, vecs[i].stopBit);
            checkOutput($sformatf("tbl%0d_level", i), fifo_level, vecs[i].expLevel);
            checkOutput($sformatf("tbl%0d_ferr", i), frame_err, vecs[i].expFerr);
            checkOutput($sformatf("tbl%0d_ovf", i), overflow, vecs[i].expOvf);
            checkOutput($sformatf("tbl%0d_head", i), m_data, vecs[i].expHead);
            checkOutput($sformatf("tbl%0d_busy", i), busy, 1'b0);
        end
        popOne("ovf_pop0", 8'h01);
        popOne("ovf_pop1", 8'h02);
        popOne("ovf_pop2", 8'h03);
        popOne("ovf_pop3", 8'h04);
        checkOutput("ovf_empty", m_valid, 1'b0);
        pulseErrClr();
        checkOutput("ovf_clr", overflow, 1'b0);
        checkOutput("ovf_ferr_clr", frame_err, 1'b0);

        // Push into a full FIFO on the same edge as a pop.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'h10 + 8'(i), 1'b1);
        end
        checkOutput("full_level", fifo_level, 3'd4);
        fork
            applyStimulus(8'h14, 1'b1);
            begin
                repeat (154) @(posedge clk);
                #1;
                m_ready = 1'b1;
                @(posedge clk);
                #1;
                m_ready = 1'b0;
            end
        join
        checkOutput("simul_level", fifo_level, 3'd4);
        checkOutput("simul_ovf", overflow, 1'b0);
        popOne("simul_pop0", 8'h11);
        popOne("simul_pop1", 8'h12);
        popOne("simul_pop2", 8'h13);
        popOne("simul_pop3", 8'h14);

        // Reset in the middle of bit 3 of 0x55 with a byte already buffered.
        applyStimulus(8'h77, 1'b1);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int b = 0; b < 3; b++) begin
            rx = (b % 2 == 0);
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx = 1'b0;
        repeat (CPB / 2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        rx = 1'b1;
        #2;
        checkOutput("midrst_valid", m_valid, 1'b0);
        checkOutput("midrst_data", m_data, 8'h00);
        checkOutput("midrst_level", fifo_level, 3'd0);
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_ferr", frame_err, 1'b0);
        checkOutput("midrst_ovf", overflow, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        #1;
        checkOutput("postrst_busy", busy, 1'b0);
        checkOutput("postrst_level", fifo_level, 3'd0);
        applyStimulus(8'h66, 1'b1);
        checkOutput("postrst_level1", fifo_level, 3'd1);
        popOne("postrst_pop", 8'h66);
        checkOutput("postrst_empty", m_valid, 1'b0);

        // Random frames against the queue model.
        mFerr = 1'b0;
        mOvf  = 1'b0;
        for (int it = 0; it < 14; it++) begin
            logic [7:0] d;
            logic       sb;
            int         k;
            d  = 8'($urandom);
            sb = ($urandom_range(0, 4) != 0);
            applyStimulus(d, sb);
            if (sb) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(d);
                end else begin
                    mOvf = 1'b1;
                end
            end else begin
                mFerr = 1'b1;
            end
            checkOutput($sformatf("rnd%0d_level", it), fifo_level, mq.size());
            checkOutput($sformatf("rnd%0d_ferr", it), frame_err, mFerr);
            checkOutput($sformatf("rnd%0d_ovf", it), overflow, mOvf);
            if ($urandom_range(0, 2) == 0) begin
                pulseErrClr();
                mFerr = 1'b0;
                mOvf  = 1'b0;
                checkOutput($sformatf("rnd%0d_clr_ferr", it), frame_err, mFerr);
                checkOutput($sformatf("rnd%0d_clr_ovf", it), overflow, mOvf);
            end
            k = $urandom_range(0, mq.size());
            for (int p = 0; p < k; p++) begin
                popOne($sformatf("rnd%0d_pop%0d", it, p), mq.pop_front());
            end
        end
        while (mq.size() > 0) begin
            popOne("rnd_drain", mq.pop_front());
        end
        checkOutput("rnd_final_valid", m_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
